// File: rtl/pc_counter_stack.sv
// ============================================================================
// pc_counter_stack
// ----------------------------------------------------------------------------
// Program counter for the processor datapath. This block supplies the
// instruction address that is sent to program memory.
//
//   - WIDTH-bit up-counter. Each enabled cycle it adds STEP.
//   - A parallel load sets the counter to a given value.
//   - wrap is a one-cycle pulse that fires when an increment carries past
//     2^WIDTH-1.
//   - An optional DEPTH-entry return-address stack supports call/return.
//
// Optional feature macro: PC_CALL_STACK_EN
//   - Defined: the return stack is built.
//   - Undefined (default): no stack storage is built.
//       * call is a plain jump.
//       * ret is ignored.
//       * level, full, empty and err are tied to their idle values.
//
// Parameters
//   WIDTH  counter / address width in bits (4..32)
//   STEP   increment added per enabled cycle (1..2^WIDTH-1)
//   DEPTH  return-stack entries (2..16)
//
// Ports
//   clk     in   rising-edge clock
//   res     in   synchronous active-high reset
//   enable  in   add STEP to out this cycle
//   load    in   out <= carga
//   carga   in   load / call target value
//   call    in   push out+1 and jump to carga
//   ret     in   pop the top entry into out
//   out     out  current count / program address
//   wrap    out  one-cycle pulse after an increment that wrapped
//   level   out  number of stack entries in use
//   full    out  level == DEPTH
//   empty   out  level == 0
//   err     out  sticky overflow/underflow flag; cleared only by res
//
// Priority per edge: res > load > call > ret > enable > hold.
// ============================================================================
module pc_counter_stack #(
    parameter int          WIDTH = 12,
    parameter int unsigned STEP  = 1,
    parameter int          DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         enable,
    input  logic                         load,
    input  logic [WIDTH-1:0]             carga,
    input  logic                         call,
    input  logic                         ret,
    output logic [WIDTH-1:0]             out,
    output logic                         wrap,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int               LW     = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W = STEP[WIDTH-1:0];

    // Counter state
    logic [WIDTH-1:0] out_r;
    logic             wrap_r;
    logic [WIDTH-1:0] out_nx_s;
    logic             wrap_nx_s;

    // The extra top bit of the sum is the carry out of the increment.
    logic [WIDTH:0]   inc_s;

    assign inc_s = {1'b0, out_r} + {1'b0, STEP_W};

`ifdef PC_CALL_STACK_EN
    // The stack index only needs enough bits to address DEPTH entries.
    // level itself needs one extra code so that it can hold DEPTH.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack_r [DEPTH];
    logic [LW-1:0]    level_r;
    logic             full_r;
    logic             empty_r;
    logic             err_r;

    logic [LW-1:0]    level_nx_s;
    logic             err_nx_s;
    logic             push_s;
    logic [LW-1:0]    pop_lvl_s;
    logic [AW-1:0]    push_idx_s;
    logic [AW-1:0]    pop_idx_s;
    logic [WIDTH-1:0] ret_addr_s;

    // Truncating to AW bits is safe here. A push happens only when the stack
    // is not full, and a pop happens only when it is not empty, so both
    // indices always lie in 0..DEPTH-1.
    assign pop_lvl_s  = level_r - {{(LW-1){1'b0}}, 1'b1};
    assign push_idx_s = level_r[AW-1:0];
    assign pop_idx_s  = pop_lvl_s[AW-1:0];
    assign ret_addr_s = out_r + {{(WIDTH-1){1'b0}}, 1'b1};

    // Next-state selection for the counter and the stack, in priority order
    always_comb begin
        out_nx_s   = out_r;
        wrap_nx_s  = 1'b0;
        level_nx_s = level_r;
        err_nx_s   = err_r;
        push_s     = 1'b0;
        if (res) begin
            out_nx_s   = {WIDTH{1'b0}};
            level_nx_s = {LW{1'b0}};
            err_nx_s   = 1'b0;
        end else if (load) begin
            // A load takes precedence over call and ret, so the stack is left untouched.
            out_nx_s = carga;
        end else if (call) begin
            // The jump always happens. On overflow the push is discarded.
            out_nx_s = carga;
            if (full_r) begin
                err_nx_s = 1'b1;
            end else begin
                push_s     = 1'b1;
                level_nx_s = level_r + {{(LW-1){1'b0}}, 1'b1};
            end
        end else if (ret) begin
            if (empty_r) begin
                err_nx_s = 1'b1;
            end else begin
                out_nx_s   = stack_r[pop_idx_s];
                level_nx_s = pop_lvl_s;
            end
        end else if (enable) begin
            {wrap_nx_s, out_nx_s} = inc_s;
        end else begin
            out_nx_s = out_r;
        end
    end

    // Registered counter, wrap pulse, stack level and the flags derived from level
    always_ff @(posedge clk) begin
        if (res) begin
            out_r   <= {WIDTH{1'b0}};
            wrap_r  <= 1'b0;
            level_r <= {LW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            out_r   <= out_nx_s;
            wrap_r  <= wrap_nx_s;
            level_r <= level_nx_s;
            // full and empty are computed from the next level. This keeps
            // them in step with the registered level in every cycle.
            full_r  <= (level_nx_s == LW'(DEPTH));
            empty_r <= (level_nx_s == {LW{1'b0}});
            err_r   <= err_nx_s;
        end
    end

    // Return-address storage. Its contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (!res && push_s) begin
            stack_r[push_idx_s] <= ret_addr_s;
        end
    end

    assign level = level_r;
    assign full  = full_r;
    assign empty = empty_r;
    assign err   = err_r;

`else
    // Next-state selection when there is no stack. call is a plain jump and ret holds.
    always_comb begin
        out_nx_s  = out_r;
        wrap_nx_s = 1'b0;
        if (res) begin
            out_nx_s = {WIDTH{1'b0}};
        end else if (load) begin
            out_nx_s = carga;
        end else if (call) begin
            out_nx_s = carga;
        end else if (ret) begin
            out_nx_s = out_r;
        end else if (enable) begin
            {wrap_nx_s, out_nx_s} = inc_s;
        end else begin
            out_nx_s = out_r;
        end
    end

    // Registered counter and wrap pulse
    always_ff @(posedge clk) begin
        if (res) begin
            out_r  <= {WIDTH{1'b0}};
            wrap_r <= 1'b0;
        end else begin
            out_r  <= out_nx_s;
            wrap_r <= wrap_nx_s;
        end
    end

    assign level = {LW{1'b0}};
    assign full  = 1'b0;
    assign empty = 1'b1;
    assign err   = 1'b0;
`endif

    assign out  = out_r;
    assign wrap = wrap_r;

endmodule
